// File: rtl/cla32_pipe_adder.sv
// rtl/cla32_pipe_adder.sv - two-stage pipelined 32-bit carry-lookahead adder with valid/ready handshake
//
// Purpose:
//   Computes sum = a + b + cin (modulo 2^32), the carry out of bit 31 and the
//   signed overflow flag. The lower half is added in stage 1 and the upper
//   half in stage 2, using one cla16btadder for each half. A valid/ready
//   handshake with full backpressure sits on both sides. The pipeline holds
//   at most two transactions.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   upstream presents an operand set
//   in_ready   out  1   operand set is accepted this cycle
//   a, b       in   32  operands
//   cin        in   1   carry-in
//   out_valid  out  1   sum/cout/ovf hold a valid result
//   out_ready  in   1   downstream takes the result this cycle
//   sum        out  32  registered a+b+cin
//   cout       out  1   registered carry out of bit 31
//   ovf        out  1   registered signed overflow

// 4-bit carry-lookahead block. It also produces the group propagate and
// group generate terms for the next lookahead level.
module cla4_block (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       pg_o,
    output logic       gg_o
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // All internal carries come from the block inputs directly; there is no ripple.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);

    assign sum_o = p ^ c;
    assign pg_o  = &p;
    assign gg_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
endmodule

// 16-bit two-level carry-lookahead adder: four 4-bit blocks and a group
// lookahead unit that computes c4, c8, c12 and c16.
module cla16btadder (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    logic [3:0] pg;
    logic [3:0] gg;
    logic [4:0] gc;

    assign gc[0] = cin_i;
    assign gc[1] = gg[0] | (pg[0] & cin_i);
    assign gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin_i);
    assign gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
                 | (pg[2] & pg[1] & pg[0] & cin_i);
    assign gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
                 | (pg[3] & pg[2] & pg[1] & gg[0])
                 | (pg[3] & pg[2] & pg[1] & pg[0] & cin_i);

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_blk
            cla4_block u_blk (
                .a_i   (a_i[4*i +: 4]),
                .b_i   (b_i[4*i +: 4]),
                .cin_i (gc[i]),
                .sum_o (sum_o[4*i +: 4]),
                .pg_o  (pg[i]),
                .gg_o  (gg[i])
            );
        end
    endgenerate

    assign cout_o = gc[4];
endmodule

module cla32_pipe_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovf
);
    // Stage 1 registers
    logic        s1_valid_q,  s1_valid_d;
    logic [15:0] s1_sum_lo_q, s1_sum_lo_d;
    logic        s1_c16_q,    s1_c16_d;
    logic [15:0] s1_a_hi_q,   s1_a_hi_d;
    logic [15:0] s1_b_hi_q,   s1_b_hi_d;

    // Stage 2 / output registers
    logic        out_valid_q, out_valid_d;
    logic [31:0] sum_q,       sum_d;
    logic        cout_q,      cout_d;
    logic        ovf_q,       ovf_d;

    logic        s1_advance;
    logic        s2_advance;

    logic [15:0] lo_sum;
    logic        lo_cout;
    logic [15:0] hi_sum;
    logic        hi_cout;

    // Each stage may accept a new entry when it is empty or when its
    // contents move on this cycle. Because of this, in_ready depends only on
    // state and out_ready and never on in_valid.
    assign s2_advance = !out_valid_q || out_ready;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign in_ready   = s1_advance;

    cla16btadder u_lo (
        .a_i    (a[15:0]),
        .b_i    (b[15:0]),
        .cin_i  (cin),
        .sum_o  (lo_sum),
        .cout_o (lo_cout)
    );

    cla16btadder u_hi (
        .a_i    (s1_a_hi_q),
        .b_i    (s1_b_hi_q),
        .cin_i  (s1_c16_q),
        .sum_o  (hi_sum),
        .cout_o (hi_cout)
    );

    // Stage 1 next state. The data registers change only on a real transfer,
    // so an idle stage keeps the last operands instead of capturing bus noise.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_lo_d = s1_sum_lo_q;
        s1_c16_d    = s1_c16_q;
        s1_a_hi_d   = s1_a_hi_q;
        s1_b_hi_d   = s1_b_hi_q;
        if (s1_advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sum_lo_d = lo_sum;
                s1_c16_d    = lo_cout;
                s1_a_hi_d   = a[31:16];
                s1_b_hi_d   = b[31:16];
            end
        end
    end

    // Stage 2 next state. The outputs are written only when a valid stage-1
    // entry moves forward. A bubble moving into stage 2 clears out_valid but
    // leaves sum/cout/ovf unchanged.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = {hi_sum, s1_sum_lo_q};
                cout_d = hi_cout;
                // Signed overflow: both operands have the same sign and the
                // sign of the result differs from it.
                ovf_d  = (s1_a_hi_q[15] == s1_b_hi_q[15]) &&
                         (hi_sum[15] != s1_a_hi_q[15]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_lo_q <= 16'h0000;
            s1_c16_q    <= 1'b0;
            s1_a_hi_q   <= 16'h0000;
            s1_b_hi_q   <= 16'h0000;
            out_valid_q <= 1'b0;
            sum_q       <= 32'h0000_0000;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_lo_q <= s1_sum_lo_d;
            s1_c16_q    <= s1_c16_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_b_hi_q   <= s1_b_hi_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla32_pipe_adder.sv
// tb/tb_cla32_pipe_adder.sv - self-checking bench for cla32_pipe_adder
module tb_cla32_pipe_adder;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp;
    int n_err;
    int cyc;

    // Reference model: results in flight, in order, each with the cycle it was accepted.
    logic [33:0] q_res[$];
    int          q_cyc[$];

    cla32_pipe_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Result packed as {cout, ovf, sum}.
    function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic c);
        logic [32:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {32'd0, c};
        v = (x[31] == y[31]) && (t[31] != x[31]);
        return {t[32], v, t[31:0]};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle. Everything is checked at the negative edge, after the
    // inputs have settled and before the DUT's next rising edge.
    task automatic step();
        logic exp_rdy;
        logic exp_vld;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
        end else begin
            exp_rdy = (q_res.size() < 2) || out_ready;
            exp_vld = (q_res.size() > 0) && ((cyc - q_cyc[0]) >= 2);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(exp_vld));
            if (exp_vld && out_valid)
                chk("result", 64'({cout, ovf, sum}), 64'(q_res[0]));
            if (exp_vld && out_ready) begin
                void'(q_res.pop_front());
                void'(q_cyc.pop_front());
            end
            if (exp_rdy && in_valid) begin
                q_res.push_back(ref_add(a, b, cin));
                q_cyc.push_back(cyc);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic c);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);

        // Reset state. Transfers offered during reset are ignored.
        step();
        step();
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();

        // Wrap-around: carry out, no overflow
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();
        chk("wrap_sum", 64'(sum), 64'h0);
        chk("wrap_cout", 64'(cout), 64'd1);
        chk("wrap_ovf", 64'(ovf), 64'd0);
        step();

        // Signed overflow
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();
        chk("ovf_sum", 64'(sum), 64'h8000_0000);
        chk("ovf_cout", 64'(cout), 64'd0);
        chk("ovf_ovf", 64'(ovf), 64'd1);
        step();

        // Carry crossing the boundary between the two stages
        drive(1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();
        chk("c16_sum", 64'(sum), 64'h0001_0000);
        chk("c16_cout", 64'(cout), 64'd0);
        step();

        // Back-to-back transfers, one result per cycle
        drive(1'b1, 32'd1, 32'd2, 1'b0);
        step();
        drive(1'b1, 32'd3, 32'd4, 1'b0);
        step();
        chk("b2b_0", 64'(sum), 64'd3);
        drive(1'b1, 32'd5, 32'd6, 1'b0);
        step();
        chk("b2b_1", 64'(sum), 64'd7);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();
        chk("b2b_2", 64'(sum), 64'd11);
        step();
        step();

        // Backpressure: fill the pipeline, then stall and release
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'd100 + 32'(i), 32'd1000, 1'b0);
            step();
        end
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_sum", 64'(sum), 64'd1100);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Asynchronous reset with two transactions in flight
        drive(1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
        step();
        drive(1'b1, 32'h0BAD_0000, 32'h0000_F00D, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_sum", 64'(sum), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        q_res.delete();
        q_cyc.delete();
        step();
        step();
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();
        step();
        drive(1'b1, 32'h10, 32'h20, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();
        chk("post_rst_sum", 64'(sum), 64'h30);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        step();

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
                  1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end

        // Drain the pipeline
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drained", 64'(q_res.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cla32_pipe_adder.md
CLA32_PIPE_ADDER -- requirements
Module: cla32_pipe_adder

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream holds a valid operand set.
REQ-005 in_ready  output  1  block accepts an operand set this cycle.
REQ-006 a  input  32  operand A, unsigned/two's complement.
REQ-007 b  input  32  operand B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  sum/cout/ovf hold a valid result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 sum  output  32  registered a+b+cin, bits [31:0].
REQ-012 cout  output  1  registered carry out of bit 31.
REQ-013 ovf  output  1  registered signed overflow: (a[31]==b[31]) && (sum[31]!=a[31]).

Function
REQ-014 Two pipeline stages; each addition half SHALL be an instance of the team's cla16btadder.
REQ-015 Stage 1 SHALL add a[15:0]+b[15:0]+cin; it registers the low sum, the carry c16, a[31:16], b[31:16] and s1_valid.
REQ-016 Stage 2 SHALL add the registered upper halves with the registered c16 as carry-in; it registers sum, cout, ovf and out_valid.
REQ-017 Input transfer occurs on a cycle with in_valid && in_ready; output transfer occurs on a cycle with out_valid && out_ready.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid high, with no backpressure.
REQ-019 Throughput SHALL be one transaction per cycle while out_ready stays high.
REQ-020 s2_advance = !out_valid || out_ready; s1_advance = !s1_valid || s2_advance; in_ready = s1_advance (combinational, no dependence on in_valid).
REQ-021 Stage 2 SHALL load from stage 1 when s2_advance is high; out_valid is then set to s1_valid.
REQ-022 Stage 1 SHALL load when s1_advance is high; s1_valid is then set to in_valid.
REQ-023 While out_valid && !out_ready, sum, cout and ovf SHALL hold stable; no result is dropped, duplicated or reordered.
REQ-024 With both stages full and out_ready low, in_ready SHALL be 0.
REQ-025 Output transfer and new input transfer in the same cycle SHALL both occur; occupancy stays unchanged.
REQ-026 Data registers of an invalid stage are don't-care internally, but sum, cout and ovf SHALL only change on a stage-2 load.
REQ-027 Arithmetic SHALL wrap modulo 2^32; cout carries the 33rd bit; ovf is computed from the operands and sum of the same transaction.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) clear s1_valid and out_valid to 0, and all data registers (sum, cout, ovf, stage-1 regs) to 0.
REQ-029 During reset, in_ready SHALL read 1 (pipeline empty); transfers presented while rst_n is low are ignored.
REQ-030 Reset mid-operation SHALL discard all in-flight transactions; the first transfer after release completes in 2 cycles.
REQ-031 Reset deassertion SHALL be synchronised externally; the block samples no inputs on the release edge's cycle beyond normal operation.

Verification
REQ-032 a=0xFFFF_FFFF, b=0x0000_0001, cin=0, out_ready=1 -> 2 cycles later sum=0x0000_0000, cout=1, ovf=0.
REQ-033 a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1.
REQ-034 a=0x0000_FFFF, b=0x0000_0000, cin=1 -> sum=0x0001_0000, cout=0 (carry crosses the stage boundary).
REQ-035 Three back-to-back transfers (1+2, 3+4, 5+6) with out_ready=1 -> results 3, 7, 11 on consecutive cycles starting 2 cycles after the first transfer.
REQ-036 out_ready=0 with in_valid=1 continuously -> two transfers accepted, in_ready=0 from the third cycle, and sum held stable; releasing out_ready for 1 cycle -> in_ready=1 on that same cycle and order is preserved.
REQ-037 rst_n pulsed low while two transactions are in flight -> out_valid=0 and sum=0 immediately, no stale result appears afterwards, and a new 0x10+0x20 transfer yields 0x30 after 2 cycles.
